// File: rtl/apsk_pkg.sv
// Shared APSK definitions used by both the transmit mapper and the demapper:
// word format, modulation modes, packer states and bits-per-symbol lookup.
package apsk_pkg;

    localparam int WORDLENGTH = 18;
    localparam int FRACTION   = 10;
    localparam int SYM_NUM    = 64;

    typedef enum logic [1:0] {
        MODE_16 = 2'd0,
        MODE_32 = 2'd1,
        MODE_64 = 2'd2
    } apsk_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } apsk_state_t;

    // The reserved mode code behaves like 64APSK.
    function automatic logic [2:0] bits_per_sym(input logic [1:0] mode);
        logic [2:0] k;
        case (mode)
            2'd0:    k = 3'd4;
            2'd1:    k = 3'd5;
            default: k = 3'd6;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/apsk_bit_packer.sv
// Packs a byte stream into k-bit symbol indices, MSB first, with frame
// handling (zero-padded final symbol, last flag) and input backpressure.
module apsk_bit_packer
    import apsk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       slot_free,
    output logic       in_ready,
    output logic       emit,
    output logic [5:0] idx,
    output logic       last
);

    apsk_state_t state_q, state_d;
    logic [12:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  k_q, k_d;
    logic [3:0]  k_s;
    logic [3:0]  cnt_shift_s;
    logic        accept_s;

    // Handshake, symbol extraction and next buffer/count/state.
    always_comb begin
        k_s      = {1'b0, k_q};
        in_ready = rst_n && (state_q != FLUSH) && (cnt_q <= 4'd5);
        accept_s = in_valid && in_ready;
        emit     = slot_free && ((cnt_q >= k_s) || ((state_q == FLUSH) && (cnt_q != 4'd0)));
        last     = emit && (state_q == FLUSH) && (cnt_q <= k_s);

        // Bits below cnt are always zero, so a short final symbol pads itself.
        case (k_q)
            3'd4:    idx = {2'b00, buf_q[12:9]};
            3'd5:    idx = {1'b0, buf_q[12:8]};
            default: idx = buf_q[12:7];
        endcase

        if (emit) begin
            cnt_shift_s = (cnt_q > k_s) ? (cnt_q - k_s) : 4'd0;
            buf_d       = buf_q << k_q;
        end else begin
            cnt_shift_s = cnt_q;
            buf_d       = buf_q;
        end

        if (accept_s) begin
            buf_d = buf_d | ({in_data, 5'b00000} >> cnt_shift_s);
            cnt_d = cnt_shift_s + 4'd8;
        end else begin
            cnt_d = cnt_shift_s;
        end

        k_d = (state_q == IDLE) ? bits_per_sym(mode) : k_q;

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = in_last ? FLUSH : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s && in_last) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (last) begin
                    state_d = IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= 13'd0;
            cnt_q   <= 4'd0;
            k_q     <= 3'd6;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: rtl/apsk_symbol_mapper.sv
// APSK transmit mapper: bit packer feeding a loadable 64-entry constellation
// table, with a registered valid/ready symbol output.
module apsk_symbol_mapper #(
    parameter int WORDLENGTH = apsk_pkg::WORDLENGTH,
    parameter int SYM_NUM    = apsk_pkg::SYM_NUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    input  logic                  lut_we,
    input  logic [5:0]            lut_addr,
    input  logic [WORDLENGTH-1:0] lut_re,
    input  logic [WORDLENGTH-1:0] lut_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORDLENGTH-1:0] out_re,
    output logic [WORDLENGTH-1:0] out_im,
    output logic [5:0]            out_idx,
    output logic                  out_last
);

    logic [WORDLENGTH-1:0] tbl_re_q [SYM_NUM];
    logic [WORDLENGTH-1:0] tbl_re_d [SYM_NUM];
    logic [WORDLENGTH-1:0] tbl_im_q [SYM_NUM];
    logic [WORDLENGTH-1:0] tbl_im_d [SYM_NUM];

    logic                  out_valid_q, out_valid_d;
    logic [WORDLENGTH-1:0] out_re_q, out_re_d;
    logic [WORDLENGTH-1:0] out_im_q, out_im_d;
    logic [5:0]            out_idx_q, out_idx_d;
    logic                  out_last_q, out_last_d;

    logic       slot_free_s;
    logic       emit_s;
    logic [5:0] idx_s;
    logic       last_s;

    assign slot_free_s = !out_valid_q || out_ready;

    apsk_bit_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .slot_free (slot_free_s),
        .in_ready  (in_ready),
        .emit      (emit_s),
        .idx       (idx_s),
        .last      (last_s)
    );

    // Table write port; an emit in the same cycle still sees the old entry.
    always_comb begin
        for (int i = 0; i < SYM_NUM; i++) begin
            tbl_re_d[i] = (lut_we && (lut_addr == 6'(i))) ? lut_re : tbl_re_q[i];
            tbl_im_d[i] = (lut_we && (lut_addr == 6'(i))) ? lut_im : tbl_im_q[i];
        end
    end

    // Constellation table storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYM_NUM; i++) begin
                tbl_re_q[i] <= '0;
                tbl_im_q[i] <= '0;
            end
        end else begin
            tbl_re_q <= tbl_re_d;
            tbl_im_q <= tbl_im_d;
        end
    end

    // Output slot: load on emit, drop on drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (emit_s) begin
            out_valid_d = 1'b1;
            out_re_d    = tbl_re_q[idx_s];
            out_im_d    = tbl_im_q[idx_s];
            out_idx_d   = idx_s;
            out_last_d  = last_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= 6'd0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_apsk_symbol_mapper.sv
// Self-checking bench for apsk_symbol_mapper: a bit-string model of each frame
// predicts the symbol sequence, checked on every output transfer.
module tb_apsk_symbol_mapper;

    localparam int WL = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'd0;
    logic          in_last = 1'b0;
    logic          lut_we = 1'b0;
    logic [5:0]    lut_addr = 6'd0;
    logic [WL-1:0] lut_re = '0;
    logic [WL-1:0] lut_im = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WL-1:0] out_re;
    logic [WL-1:0] out_im;
    logic [5:0]    out_idx;
    logic          out_last;

    apsk_symbol_mapper dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_re(lut_re), .lut_im(lut_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]    idx;
        logic [WL-1:0] re;
        logic [WL-1:0] im;
        logic          last;
    } sym_t;

    sym_t          exp_q[$];
    logic [WL-1:0] m_re [64];
    logic [WL-1:0] m_im [64];
    int            n_checks = 0;
    int            n_errors = 0;
    int            rdy_pct = 100;
    bit            force_low = 1'b0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output sink with randomised backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = force_low ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Compare process: every transfer against the model, every stall for stability.
    initial begin
        sym_t prev;
        sym_t e;
        bit   stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_idx", 64'(out_idx), 64'(prev.idx));
                    check("hold_re", 64'(out_re), 64'(prev.re));
                    check("hold_im", 64'(out_im), 64'(prev.im));
                    check("hold_last", 64'(out_last), 64'(prev.last));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_symbol: got idx 0x%0h, expected none at %0t", out_idx, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("sym_idx", 64'(out_idx), 64'(e.idx));
                        check("sym_re", 64'(out_re), 64'(e.re));
                        check("sym_im", 64'(out_im), 64'(e.im));
                        check("sym_last", 64'(out_last), 64'(e.last));
                    end
                end
                stall_prev = out_valid && !out_ready;
                prev.idx  = out_idx;
                prev.re   = out_re;
                prev.im   = out_im;
                prev.last = out_last;
            end
        end
    end

    // Reference: frame as a bit string, cut into k-bit chunks, last chunk zero-padded.
    task automatic expect_frame(input int m, input logic [7:0] b[$]);
        int   k;
        int   total;
        int   sidx;
        int   p;
        logic [7:0] byte_v;
        sym_t s;
        k = (m == 0) ? 4 : ((m == 1) ? 5 : 6);
        total = 8 * b.size();
        for (int pos = 0; pos < total; pos += k) begin
            sidx = 0;
            for (int j = 0; j < k; j++) begin
                p = pos + j;
                sidx = sidx * 2;
                if (p < total) begin
                    byte_v = b[p / 8];
                    sidx = sidx + int'(byte_v[7 - (p % 8)]);
                end
            end
            s.idx  = 6'(sidx);
            s.re   = m_re[sidx];
            s.im   = m_im[sidx];
            s.last = (pos + k >= total);
            exp_q.push_back(s);
        end
    endtask

    task automatic load_entry(input int a, input logic [WL-1:0] re, input logic [WL-1:0] im);
        lut_we = 1'b1;
        lut_addr = 6'(a);
        lut_re = re;
        lut_im = im;
        tick();
        lut_we = 1'b0;
        m_re[a] = re;
        m_im[a] = im;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
        int w = 0;
        ok = 1'b1;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 500) begin
                n_checks++;
                n_errors++;
                $display("FAIL in_ready_timeout: got 0, expected 1 within 500 cycles at %0t", $time);
                ok = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_frame(input int m, input logic [7:0] b[$], input int gap_max, input bit chk_lat);
        bit ok;
        mode = 2'(m);
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], (i == b.size() - 1), ok);
            if (!ok) return;
            if (i == 0) begin
                mode = 2'($urandom_range(0, 3));
                if (chk_lat) begin
                    check("latency_before", 64'(out_valid), 64'd0);
                    tick();
                    check("latency_after", 64'(out_valid), 64'd1);
                end
            end
            repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            tick();
            w++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b[$];
        int lit_idx[4];
        int lit_re[4];
        bit ok;
        for (int i = 0; i < 64; i++) begin
            m_re[i] = '0;
            m_im[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_re", 64'(out_re), 64'd0);
        check("rst_out_im", 64'(out_im), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        mon_en = 1'b1;
        rdy_pct = 100;

        // 16APSK: A5, 3C
        for (int i = 0; i < 16; i++) load_entry(i, 18'(i * 18'h00400), 18'd0);
        b = '{8'hA5, 8'h3C};
        expect_frame(0, b);
        lit_idx = '{10, 5, 3, 12};
        lit_re  = '{32'h02800, 32'h01400, 32'h00C00, 32'h03000};
        check("t1_model_size", 64'(exp_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_model_idx", 64'(exp_q[i].idx), 64'(lit_idx[i]));
            check("t1_model_re", 64'(exp_q[i].re), 64'(lit_re[i]));
            check("t1_model_last", 64'(exp_q[i].last), 64'(i == 3));
        end
        send_frame(0, b, 0, 1'b1);
        wait_drain();

        // 64APSK: FC 0F C3 -> 63 0 63 3, no padding
        for (int i = 0; i < 64; i++) load_entry(i, 18'($urandom), 18'($urandom));
        b = '{8'hFC, 8'h0F, 8'hC3};
        expect_frame(2, b);
        lit_idx = '{63, 0, 63, 3};
        check("t2_model_size", 64'(exp_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_model_idx", 64'(exp_q[i].idx), 64'(lit_idx[i]));
            check("t2_model_last", 64'(exp_q[i].last), 64'(i == 3));
        end
        send_frame(2, b, 1, 1'b0);
        wait_drain();

        // 32APSK: B4 -> 22 then padded 16
        load_entry(22, 18'h00400, 18'h3FC00);
        b = '{8'hB4};
        expect_frame(1, b);
        check("t3_model_size", 64'(exp_q.size()), 64'd2);
        check("t3_model_idx0", 64'(exp_q[0].idx), 64'd22);
        check("t3_model_re0", 64'(exp_q[0].re), 64'h00400);
        check("t3_model_im0", 64'(exp_q[0].im), 64'h3FC00);
        check("t3_model_idx1", 64'(exp_q[1].idx), 64'd16);
        check("t3_model_last1", 64'(exp_q[1].last), 64'd1);
        send_frame(1, b, 0, 1'b0);
        wait_drain();
        check("t3_idle_in_ready", 64'(in_ready), 64'd1);

        // Table write on the same edge entry 5 is emitted
        load_entry(5, 18'h11111, 18'h22222);
        tick();
        mode = 2'd0;
        exp_q.push_back('{idx: 6'd5, re: 18'h11111, im: 18'h22222, last: 1'b0});
        exp_q.push_back('{idx: 6'd5, re: 18'h33333, im: 18'h04444, last: 1'b1});
        send_byte(8'h55, 1'b1, ok);
        lut_we = 1'b1;
        lut_addr = 6'd5;
        lut_re = 18'h33333;
        lut_im = 18'h04444;
        tick();
        lut_we = 1'b0;
        m_re[5] = 18'h33333;
        m_im[5] = 18'h04444;
        wait_drain();
        b = '{8'h5F};
        expect_frame(0, b);
        send_frame(0, b, 0, 1'b0);
        wait_drain();

        // Backpressure: out_ready low for 10 cycles
        force_low = 1'b1;
        repeat (2) tick();
        b = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        expect_frame(2, b);
        fork
            send_frame(2, b, 0, 1'b0);
            begin
                repeat (6) tick();
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_out_valid_high", 64'(out_valid), 64'd1);
                repeat (4) tick();
                force_low = 1'b0;
            end
        join
        wait_drain();

        // Reset in the middle of a frame
        mon_en = 1'b0;
        force_low = 1'b1;
        tick();
        mode = 2'd1;
        send_byte(8'hAA, 1'b0, ok);
        send_byte(8'h3C, 1'b0, ok);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_out_last", 64'(out_last), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            m_re[i] = '0;
            m_im[i] = '0;
        end
        repeat (2) tick();
        rst_n = 1'b1;
        force_low = 1'b0;
        tick();
        check("after_rst_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;
        b = '{8'h5A};
        expect_frame(0, b);
        send_frame(0, b, 0, 1'b0);
        wait_drain();

        // Randomised frames with random backpressure
        rdy_pct = 60;
        for (int f = 0; f < 40; f++) begin
            int m;
            int len;
            if ((f % 5) == 0) begin
                wait_drain();
                for (int j = 0; j < 8; j++) begin
                    load_entry($urandom_range(0, 63), 18'($urandom), 18'($urandom));
                end
            end
            m = $urandom_range(0, 3);
            len = $urandom_range(1, 6);
            b.delete();
            for (int j = 0; j < len; j++) b.push_back(8'($urandom));
            expect_frame(m, b);
            send_frame(m, b, 2, 1'b0);
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
